// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e           : receiver FSM states
//   UART_DATA_BITS       : payload bits per frame (8N1)
//   CLKS_PER_BIT_DEFAULT : 40 MHz system clock at 9600 baud
//   clog2()              : ceil(log2(v)), used for counter and pointer widths
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 4167;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte stream from the UART receiver to firmware-facing logic.
//   rx_data  : FIFO head byte, meaningful only while rx_valid=1
//   rx_valid : FIFO not empty
//   rx_ready : consumer accepts; a pop happens when rx_valid & rx_ready
// master = receiver side, slave = consumer side.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO with extra-MSB pointers.
//   clk, rst  : system clock, synchronous active-high reset
//   push      : write push_data this cycle (if room, or if popping)
//   pop       : remove head entry (ignored when empty)
//   rd_data   : head entry, combinational from registered state
//   empty/full: occupancy status
//   drop      : push rejected because the FIFO was full and not popping
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic                      empty,
    output logic                      full,
    output logic                      drop
);
    localparam int unsigned AW = clog2(FIFO_DEPTH);

    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic                      do_push;
    logic                      do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A simultaneous pop frees the slot the push needs, so a full FIFO
    // still accepts the byte and occupancy stays the same.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: synchronizer, bit-timing FSM, RX FIFO and sticky flags.
//   wb_clk_i, wb_rst_i : system clock, synchronous active-high reset
//   ser_rx             : asynchronous serial line, idle high
//   rx                 : valid/ready byte stream (master side)
//   rx_busy            : a frame is in progress
//   frame_err          : sticky, stop bit sampled low
//   overrun            : sticky, byte dropped on a full FIFO
//   err_clear          : pulse clears both sticky flags (a set event wins)
//   irq                : registered OR of rx_valid, frame_err and overrun
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          ser_rx,
    uart_rx_if.master     rx,
    output logic          rx_busy,
    output logic          frame_err,
    output logic          overrun,
    input  logic          err_clear,
    output logic          irq
);
    localparam int unsigned CNT_W = clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [2:0]       BIT_LAST    = 3'(UART_DATA_BITS - 1);

    logic [1:0]                sync_q;
    logic                      rxs;
    rx_state_e                 state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [2:0]                bit_idx, bit_idx_n;
    logic [UART_DATA_BITS-1:0] shift, shift_n;
    logic                      push_q, push_n;
    logic                      ferr_set;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      fifo_drop;

    assign rxs     = sync_q[1];
    assign rx_busy = (state != IDLE);

    // The counter free-runs and wraps; states that need a fresh
    // reference point override it with zero.
    always_comb begin
        state_n   = state;
        cnt_n     = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        push_n    = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF_M1) begin
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n     = '0;
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_n[bit_idx] = rxs;
                    bit_idx_n        = bit_idx + 3'd1;
                    if (bit_idx == BIT_LAST) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    if (rxs) begin
                        push_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q    <= '1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], ser_rx};
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            push_q    <= push_n;
            frame_err <= ferr_set  | (frame_err & ~err_clear);
            overrun   <= fifo_drop | (overrun & ~err_clear);
            irq       <= ~fifo_empty | frame_err | overrun;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push_q),
        .push_data (shift),
        .pop       (rx.rx_valid & rx.rx_ready),
        .rd_data   (rx.rx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    assign rx.rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a bit-level UART transmitter drives
// ser_rx, expected bytes go into a scoreboard queue as they are sent and
// are popped and compared as the DUT presents them.
module tb_uart_rx_core;
    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic ser_rx;
    logic rx_busy;
    logic frame_err;
    logic overrun;
    logic err_clear;
    logic irq;

    uart_rx_if rx_if ();

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .ser_rx    (ser_rx),
        .rx        (rx_if.master),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clear (err_clear),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] sb[$];
    logic exp_overrun = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame starts at a negedge; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        ser_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        ser_rx = stop_val;
        repeat (CPB) @(negedge clk);
    endtask

    // Scoreboard model: the FIFO keeps the oldest DEPTH bytes.
    task automatic expect_byte(input logic [7:0] d);
        if (sb.size() < DEPTH) sb.push_back(d);
        else exp_overrun = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (rx_if.rx_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, rx_if.rx_valid, 1);
    endtask

    task automatic pop_one();
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_valid({tag, "_wait"}, 400);
            check({tag, "_data"}, rx_if.rx_data, e);
            pop_one();
        end
        check({tag, "_empty"}, rx_if.rx_valid, 0);
    endtask

    initial begin
        repeat (20000) @(negedge clk);
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst            = 1'b1;
        ser_rx         = 1'b1;
        err_clear      = 1'b0;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", rx_if.rx_valid, 0);
        check("rst_data", rx_if.rx_data, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_irq", irq, 0);
        repeat (5) @(negedge clk);

        // 1: single byte, latency bound, irq lag, pop
        expect_byte(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_valid("t1_latency", 9*CPB + 8 + 4);
                check("t1_data", rx_if.rx_data, sb.pop_front());
                check("t1_irq_lag", irq, 0);
                @(negedge clk);
                check("t1_irq", irq, 1);
            end
        join
        pop_one();
        check("t1_popped", rx_if.rx_valid, 0);
        repeat (3) @(negedge clk);
        check("t1_irq_clear", irq, 0);

        // 2: short glitch is a false start
        ser_rx = 1'b0;
        repeat (4) @(negedge clk);
        ser_rx = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rx_busy) seen = 1;
        end
        check("t2_busy_seen", seen, 1);
        check("t2_busy_end", rx_busy, 0);
        check("t2_valid", rx_if.rx_valid, 0);
        check("t2_ferr", frame_err, 0);

        // 3: bad stop bit then held-low line
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        ser_rx = 1'b1;
        repeat (6) @(negedge clk);
        check("t3_ferr", frame_err, 1);
        check("t3_valid", rx_if.rx_valid, 0);
        check("t3_single_frame", rx_busy, 0);
        check("t3_irq", irq, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("t3_ferr_clr", frame_err, 0);
        repeat (2) @(negedge clk);
        check("t3_irq_clr", irq, 0);

        // 4: overrun keeps the oldest bytes
        for (int i = 1; i <= 5; i++) begin
            expect_byte(8'(i));
            send_frame(8'(i), 1'b1);
        end
        ser_rx = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_overrun", overrun, exp_overrun);
        check("t4_irq", irq, 1);
        drain("t4");
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        exp_overrun = 1'b0;
        check("t4_ovr_clr", overrun, 0);

        // 5: back-to-back extremes
        expect_byte(8'h00);
        send_frame(8'h00, 1'b1);
        expect_byte(8'hFF);
        send_frame(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        drain("t5");
        check("t5_ferr", frame_err, 0);
        check("t5_ovr", overrun, 0);

        // 6: reset mid-frame; leave a byte and a flag pending first
        send_frame(8'h77, 1'b1);
        send_frame(8'h00, 1'b0);
        ser_rx = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_pre_ferr", frame_err, 1);
        check("t6_pre_valid", rx_if.rx_valid, 1);
        fork
            send_frame(8'hF8, 1'b1);
            begin
                repeat (8 + 3*CPB + 8) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("t6_valid", rx_if.rx_valid, 0);
                check("t6_data", rx_if.rx_data, 0);
                check("t6_busy", rx_busy, 0);
                check("t6_ferr", frame_err, 0);
                check("t6_ovr", overrun, 0);
                check("t6_irq", irq, 0);
            end
        join
        ser_rx = 1'b1;
        repeat (200) @(negedge clk);
        check("t6_no_partial", rx_if.rx_valid, 0);
        expect_byte(8'h5A);
        send_frame(8'h5A, 1'b1);
        drain("t6_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
